// File: rtl/xobject_bank.sv
// xobject_bank: object-window write responder holding per-object sprite state.
// Software writes a shadow copy; the shadow moves to the active copy only on a
// frame_start while a commit is pending, so the renderer always sees whole frames.
module xobject_bank #(
  parameter int N_OBJ         = 4,
  parameter int COORD_W       = 10,
  parameter int OBJECT_ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic                       we,
  input  logic [OBJECT_ADDR_W-1:0]   addr,
  input  logic [31:0]                data_in,
  input  logic                       frame_start,
  output logic [N_OBJ*COORD_W-1:0]   obj_x,
  output logic [N_OBJ*COORD_W-1:0]   obj_y,
  output logic [N_OBJ-1:0]           obj_en,
  output logic [31:0]                rd_data
);

  localparam logic [OBJECT_ADDR_W-1:0] COMMIT_OFF = '1;
  localparam logic [OBJECT_ADDR_W-1:0] CLEAR_OFF  = COMMIT_OFF - OBJECT_ADDR_W'(1);

  logic [COORD_W-1:0] shadow_x [N_OBJ];
  logic [COORD_W-1:0] shadow_y [N_OBJ];
  logic [N_OBJ-1:0]   shadow_en;
  logic [COORD_W-1:0] active_x [N_OBJ];
  logic [COORD_W-1:0] active_y [N_OBJ];
  logic [N_OBJ-1:0]   active_en;
  logic               pending;
  logic [7:0]         frame_cnt;

  logic               wr;
  logic               clear_wr;
  logic               commit_wr;
  logic               xfer;
  logic [N_OBJ-1:0]   obj_wr;
  logic               unused_data;

  // Only x, y and the enable bit of the write data are stored.
  assign unused_data = ^data_in;

  // Decode the write strobe into object, CLEAR and COMMIT writes.
  always_comb begin
    wr        = sel & we;
    clear_wr  = wr && (addr == CLEAR_OFF);
    commit_wr = wr && (addr == COMMIT_OFF);
    xfer      = frame_start & pending;
    for (int unsigned k = 0; k < N_OBJ; k++) begin
      obj_wr[k] = wr && (addr == OBJECT_ADDR_W'(k));
    end
  end

  // Shadow copy: software-visible, updated by object writes and CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_OBJ; k++) begin
        shadow_x[k] <= '0;
        shadow_y[k] <= '0;
      end
      shadow_en <= '0;
    end else if (clear_wr) begin
      for (int unsigned k = 0; k < N_OBJ; k++) begin
        shadow_x[k] <= '0;
        shadow_y[k] <= '0;
      end
      shadow_en <= '0;
    end else begin
      for (int unsigned k = 0; k < N_OBJ; k++) begin
        if (obj_wr[k]) begin
          shadow_x[k]  <= data_in[COORD_W-1:0];
          shadow_y[k]  <= data_in[16+COORD_W-1:16];
          shadow_en[k] <= data_in[31];
        end
      end
    end
  end

  // Active copy, commit flag and frame counter; the copy reads the pre-edge
  // shadow, so a same-edge write or CLEAR lands only in the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_OBJ; k++) begin
        active_x[k] <= '0;
        active_y[k] <= '0;
      end
      active_en <= '0;
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (xfer) begin
        for (int unsigned k = 0; k < N_OBJ; k++) begin
          active_x[k] <= shadow_x[k];
          active_y[k] <= shadow_y[k];
        end
        active_en <= shadow_en;
      end
      if (frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      // A same-edge COMMIT re-arms the flag even as a transfer consumes it.
      if (commit_wr) begin
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
    end
  end

  // Pack the active copy for the renderer and form the status word.
  always_comb begin
    obj_x = '0;
    obj_y = '0;
    for (int unsigned k = 0; k < N_OBJ; k++) begin
      obj_x[k*COORD_W +: COORD_W] = active_x[k];
      obj_y[k*COORD_W +: COORD_W] = active_y[k];
    end
    obj_en  = active_en;
    rd_data = {23'b0, frame_cnt, pending};
  end

endmodule

// File: tb/tb_xobject_bank.sv
// tb_xobject_bank: table-driven vectors with a scoreboard queue for xobject_bank.
module tb_xobject_bank;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] data_in;
  logic        frame_start;
  logic [39:0] obj_x;
  logic [39:0] obj_y;
  logic [3:0]  obj_en;
  logic [31:0] rd_data;

  xobject_bank #(
    .N_OBJ(4),
    .COORD_W(10),
    .OBJECT_ADDR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .we(we),
    .addr(addr),
    .data_in(data_in),
    .frame_start(frame_start),
    .obj_x(obj_x),
    .obj_y(obj_y),
    .obj_en(obj_en),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sel;
    logic        we;
    logic        fs;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [39:0] ex;
    logic [39:0] ey;
    logic [3:0]  een;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    logic [39:0] ex;
    logic [39:0] ey;
    logic [3:0]  een;
    logic [31:0] erd;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [39:0] pk(int a3, int a2, int a1, int a0);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic add(input logic r, input logic s, input logic w, input logic f,
                     input logic [3:0] a, input logic [31:0] d,
                     input logic [39:0] ex, input logic [39:0] ey,
                     input logic [3:0] een, input logic [31:0] erd);
    vecs.push_back('{r, s, w, f, a, d, ex, ey, een, erd});
  endtask

  task automatic chk(input string nm, input int id, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, id, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input logic r, input logic s, input logic w, input logic f,
                       input logic [3:0] a, input logic [31:0] d, input exp_t e);
    exp_t got;
    rst = r; sel = s; we = w; frame_start = f; addr = a; data_in = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("obj_x",   got.id, obj_x,          got.ex);
    chk("obj_y",   got.id, obj_y,          got.ey);
    chk("obj_en",  got.id, 40'(obj_en),    40'(got.een));
    chk("rd_data", got.id, 40'(rd_data),   40'(got.erd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] z;
    logic [39:0] hx, hy;
    int          cnt;
    exp_t        e;
    z = '0;
    rst = 1'b1; sel = 1'b0; we = 1'b0; frame_start = 1'b0; addr = '0; data_in = '0;

    // reset wins over concurrent writes and frame_start
    add(1,1,1,1, 4'd0,  32'h8005_0064, z, z, 4'b0000, 0);
    add(1,1,1,1, 4'd15, 32'h1234_5678, z, z, 4'b0000, 0);
    // basic commit
    add(0,1,1,0, 4'd0,  32'h8005_0064, z, z, 4'b0000, 0);
    add(0,1,1,0, 4'd15, 32'h0,         z, z, 4'b0000, 1);
    add(0,0,0,0, 4'd0,  32'h0,         z, z, 4'b0000, 1);
    add(0,0,0,1, 4'd0,  32'h0,         pk(0,0,0,100), pk(0,0,0,5), 4'b0001, 2);
    // frame without commit
    add(0,1,1,0, 4'd1,  32'h8010_0020, pk(0,0,0,100), pk(0,0,0,5), 4'b0001, 2);
    add(0,0,0,1, 4'd0,  32'h0,         pk(0,0,0,100), pk(0,0,0,5), 4'b0001, 4);
    add(0,1,1,0, 4'd15, 32'h0,         pk(0,0,0,100), pk(0,0,0,5), 4'b0001, 5);
    add(0,0,0,1, 4'd0,  32'h0,         pk(0,0,32,100), pk(0,0,16,5), 4'b0011, 6);
    // object write on a transferring edge
    add(0,1,1,0, 4'd0,  32'h8003_0007, pk(0,0,32,100), pk(0,0,16,5), 4'b0011, 6);
    add(0,1,1,0, 4'd15, 32'h0,         pk(0,0,32,100), pk(0,0,16,5), 4'b0011, 7);
    add(0,1,1,1, 4'd0,  32'h0000_0001, pk(0,0,32,7), pk(0,0,16,3), 4'b0011, 8);
    // COMMIT on a transferring edge keeps pending set
    add(0,1,1,0, 4'd15, 32'h0,         pk(0,0,32,7), pk(0,0,16,3), 4'b0011, 9);
    add(0,1,1,1, 4'd15, 32'h0,         pk(0,0,32,1), pk(0,0,16,0), 4'b0010, 11);
    add(0,0,0,1, 4'd0,  32'h0,         pk(0,0,32,1), pk(0,0,16,0), 4'b0010, 12);
    // COMMIT with frame_start while idle: no transfer yet
    add(0,1,1,0, 4'd2,  32'h8001_0002, pk(0,0,32,1), pk(0,0,16,0), 4'b0010, 12);
    add(0,1,1,1, 4'd15, 32'h0,         pk(0,0,32,1), pk(0,0,16,0), 4'b0010, 15);
    add(0,0,0,1, 4'd0,  32'h0,         pk(0,2,32,1), pk(0,1,16,0), 4'b0110, 16);
    // CLEAR on a transferring edge: active gets the pre-clear shadow
    add(0,1,1,0, 4'd3,  32'h8002_0003, pk(0,2,32,1), pk(0,1,16,0), 4'b0110, 16);
    add(0,1,1,0, 4'd15, 32'h0,         pk(0,2,32,1), pk(0,1,16,0), 4'b0110, 17);
    add(0,1,1,1, 4'd14, 32'h0,         pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 18);
    // ignored accesses
    add(0,1,1,0, 4'd5,  32'hFFFF_FFFF, pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 18);
    add(0,1,1,0, 4'd13, 32'hFFFF_FFFF, pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 18);
    add(0,0,1,0, 4'd0,  32'hFFFF_FFFF, pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 18);
    add(0,1,0,0, 4'd1,  32'hFFFF_FFFF, pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 18);
    add(0,0,1,0, 4'd15, 32'h0,         pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 18);
    add(0,1,0,0, 4'd15, 32'h0,         pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 18);
    // truncated coordinates, enable clear; everything else cleared
    add(0,1,1,0, 4'd2,  32'h7ABC_1C05, pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 18);
    add(0,1,1,0, 4'd15, 32'h0,         pk(3,2,32,1), pk(2,1,16,0), 4'b1110, 19);
    add(0,0,0,1, 4'd0,  32'h0,         pk(0,5,0,0), pk(0,700,0,0), 4'b0000, 20);

    for (int i = 0; i < vecs.size(); i++) begin
      e = '{vecs[i].ex, vecs[i].ey, vecs[i].een, vecs[i].erd, i};
      apply(vecs[i].rst, vecs[i].sel, vecs[i].we, vecs[i].fs, vecs[i].addr, vecs[i].data, e);
    end

    // frame counter wrap: 256 pulses return to the starting count
    hx  = pk(0,5,0,0);
    hy  = pk(0,700,0,0);
    cnt = 10;
    for (int i = 0; i < 256; i++) begin
      cnt = (cnt + 1) % 256;
      e = '{hx, hy, 4'b0000, 32'(cnt) << 1, 100 + i};
      apply(0, 0, 0, 1, 4'd0, 32'h0, e);
    end

    // reset with a commit pending: shadow and commit are discarded
    e = '{hx, hy, 4'b0000, 32'd20, 400};
    apply(0, 1, 1, 0, 4'd0, 32'h8005_0064, e);
    e = '{hx, hy, 4'b0000, 32'd21, 401};
    apply(0, 1, 1, 0, 4'd15, 32'h0, e);
    e = '{z, z, 4'b0000, 32'd0, 402};
    apply(1, 1, 1, 1, 4'd1, 32'h8010_0020, e);
    e = '{z, z, 4'b0000, 32'd2, 403};
    apply(0, 0, 0, 1, 4'd0, 32'h0, e);
    e = '{z, z, 4'b0000, 32'd3, 404};
    apply(0, 1, 1, 0, 4'd15, 32'h0, e);
    e = '{z, z, 4'b0000, 32'd4, 405};
    apply(0, 0, 0, 1, 4'd0, 32'h0, e);

    rst = 1'b0; sel = 1'b0; we = 1'b0; frame_start = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
